// File: rtl/dram_access_arbiter.sv
// Arbitrates the single DRAM burst command port between the high-priority frame
// prefetch reads and the image-load writes, with write anti-starvation and per-direction credit limits.
module dram_access_arbiter #(
   parameter int DRAM_ADDR_WIDTH    = 39,
   parameter int MAX_OUTSTANDING_RD = 4,
   parameter int MAX_OUTSTANDING_WR = 4,
   parameter int WRITE_STARVE_LIMIT = 4
) (
   input  logic                       s_axi_aclk,
   input  logic                       s_axi_aresetn,
   input  logic                       rd_req_valid,
   input  logic [DRAM_ADDR_WIDTH-1:0] rd_req_addr,
   input  logic [7:0]                 rd_req_len,
   output logic                       rd_req_ready,
   input  logic                       wr_req_valid,
   input  logic [DRAM_ADDR_WIDTH-1:0] wr_req_addr,
   input  logic [7:0]                 wr_req_len,
   output logic                       wr_req_ready,
   output logic                       mem_cmd_valid,
   input  logic                       mem_cmd_ready,
   output logic                       mem_cmd_write,
   output logic [DRAM_ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [7:0]                 mem_cmd_len,
   input  logic                       mem_rd_valid,
   input  logic                       mem_rd_last,
   input  logic                       mem_wr_done,
   output logic                       rd_busy,
   output logic                       wr_busy,
   output logic                       err_underflow
);

   localparam int RD_CW = $clog2(MAX_OUTSTANDING_RD + 1);
   localparam int WR_CW = $clog2(MAX_OUTSTANDING_WR + 1);
   localparam int SW    = $clog2(WRITE_STARVE_LIMIT + 1);
   localparam logic [RD_CW-1:0] RD_MAX     = RD_CW'(MAX_OUTSTANDING_RD);
   localparam logic [WR_CW-1:0] WR_MAX     = WR_CW'(MAX_OUTSTANDING_WR);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(WRITE_STARVE_LIMIT);

   typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;

   state_e                     state_q, state_d;
   logic                       cmd_write_q, cmd_write_d;
   logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [7:0]                 cmd_len_q, cmd_len_d;
   logic [RD_CW-1:0]           rd_cnt_q, rd_cnt_d;
   logic [WR_CW-1:0]           wr_cnt_q, wr_cnt_d;
   logic [SW-1:0]              starve_q, starve_d;
   logic                       err_q, err_d;

   logic rd_elig, wr_elig, arb_en, grant_rd, grant_wr;
   logic cmd_hs, rd_inc, rd_dec, wr_inc, wr_dec, rd_uflow, wr_uflow;

   // Grants are gated by reset so no requester sees an acceptance while the block is held in reset.
   always_comb begin
      rd_elig  = rd_req_valid && (rd_cnt_q < RD_MAX);
      wr_elig  = wr_req_valid && (wr_cnt_q < WR_MAX);
      arb_en   = s_axi_aresetn && (state_q == ST_IDLE);
      grant_wr = arb_en && wr_elig && ((starve_q == STARVE_MAX) || !rd_elig);
      grant_rd = arb_en && rd_elig && !grant_wr;
   end

   always_comb begin
      cmd_hs = (state_q == ST_ISSUE) && mem_cmd_ready;
      rd_inc = cmd_hs && !cmd_write_q;
      wr_inc = cmd_hs && cmd_write_q;
      rd_dec = mem_rd_valid && mem_rd_last;
      wr_dec = mem_wr_done;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      rd_uflow = 1'b0;
      if (rd_inc && !rd_dec) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
      end else if (rd_dec && !rd_inc) begin
         if (rd_cnt_q == '0) rd_uflow = 1'b1;
         else                rd_cnt_d = rd_cnt_q - 1'b1;
      end

      wr_cnt_d = wr_cnt_q;
      wr_uflow = 1'b0;
      if (wr_inc && !wr_dec) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end else if (wr_dec && !wr_inc) begin
         if (wr_cnt_q == '0) wr_uflow = 1'b1;
         else                wr_cnt_d = wr_cnt_q - 1'b1;
      end

      err_d = err_q || rd_uflow || wr_uflow;
   end

   always_comb begin
      starve_d = starve_q;
      if (!wr_req_valid || grant_wr) begin
         starve_d = '0;
      end else if (grant_rd && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_len_d   = cmd_len_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_rd || grant_wr) begin
               state_d     = ST_ISSUE;
               cmd_write_d = grant_wr;
               cmd_addr_d  = grant_wr ? wr_req_addr : rd_req_addr;
               cmd_len_d   = grant_wr ? wr_req_len : rd_req_len;
            end
         end
         ST_ISSUE: begin
            if (mem_cmd_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q     <= ST_IDLE;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         starve_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_len_q   <= cmd_len_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         starve_q    <= starve_d;
         err_q       <= err_d;
      end
   end

   assign rd_req_ready  = grant_rd;
   assign wr_req_ready  = grant_wr;
   assign mem_cmd_valid = (state_q == ST_ISSUE);
   assign mem_cmd_write = cmd_write_q;
   assign mem_cmd_addr  = cmd_addr_q;
   assign mem_cmd_len   = cmd_len_q;
   assign rd_busy       = (rd_cnt_q != '0) || ((state_q == ST_ISSUE) && !cmd_write_q);
   assign wr_busy       = (wr_cnt_q != '0) || ((state_q == ST_ISSUE) && cmd_write_q);
   assign err_underflow = err_q;

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Scoreboard bench for dram_access_arbiter: random requesters and DRAM master, a
// transaction-level reference model, and a monitor that checks every issued command.
module tb_dram_access_arbiter;

   localparam int AW     = 39;
   localparam int MAX_RD = 4;
   localparam int MAX_WR = 4;
   localparam int LIMIT  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
   logic [AW-1:0] rd_req_addr, wr_req_addr, mem_cmd_addr;
   logic [7:0]    rd_req_len, wr_req_len, mem_cmd_len;
   logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
   logic          mem_rd_valid, mem_rd_last, mem_wr_done;
   logic          rd_busy, wr_busy, err_underflow;

   always #5 clk = ~clk;

   dram_access_arbiter #(
      .DRAM_ADDR_WIDTH(AW), .MAX_OUTSTANDING_RD(MAX_RD),
      .MAX_OUTSTANDING_WR(MAX_WR), .WRITE_STARVE_LIMIT(LIMIT)
   ) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_ready(rd_req_ready),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_ready(wr_req_ready),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_rd_valid(mem_rd_valid), .mem_rd_last(mem_rd_last), .mem_wr_done(mem_wr_done),
      .rd_busy(rd_busy), .wr_busy(wr_busy), .err_underflow(err_underflow)
   );

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } cmd_t;

   cmd_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Traffic knobs (percent chances per cycle), written only by the main sequence.
   int rd_prob = 0, wr_prob = 0, rdy_prob = 100, rd_cpl_prob = 100, wr_cpl_prob = 100, drop_prob = 0;
   int inject_req = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[AW-1:0];
   endfunction

   // Requesters and DRAM master: inputs change only #1 after the rising edge.
   initial begin
      int rd_pend = 0, wr_pend = 0, inject_seen = 0;
      bit rd_acc, wr_acc, rd_drop, wr_drop;
      rd_req_valid = 0; rd_req_addr = '0; rd_req_len = '0;
      wr_req_valid = 0; wr_req_addr = '0; wr_req_len = '0;
      mem_cmd_ready = 0; mem_rd_valid = 0; mem_rd_last = 0; mem_wr_done = 0;
      forever begin
         @(negedge clk);
         rd_acc = rd_req_valid && rd_req_ready;
         wr_acc = wr_req_valid && wr_req_ready;
         if (rst_n && mem_cmd_valid && mem_cmd_ready) begin
            if (mem_cmd_write) wr_pend++;
            else               rd_pend++;
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rd_pend = 0;
            wr_pend = 0;
         end
         rd_drop = rd_req_valid && !rd_acc && ($urandom_range(99) < drop_prob);
         wr_drop = wr_req_valid && !wr_acc && ($urandom_range(99) < drop_prob);
         if (rd_acc || rd_drop) rd_req_valid = 0;
         if (wr_acc || wr_drop) wr_req_valid = 0;
         if (!rd_req_valid && !rd_drop && ($urandom_range(99) < rd_prob)) begin
            rd_req_valid = 1; rd_req_addr = rand_addr(); rd_req_len = 8'($urandom_range(255));
         end
         if (!wr_req_valid && !wr_drop && ($urandom_range(99) < wr_prob)) begin
            wr_req_valid = 1; wr_req_addr = rand_addr(); wr_req_len = 8'($urandom_range(255));
         end
         mem_rd_valid = 0;
         mem_rd_last  = 1'($urandom_range(1));
         mem_wr_done  = 0;
         if (rd_pend > 0 && ($urandom_range(99) < rd_cpl_prob)) begin
            mem_rd_valid = 1; mem_rd_last = 1; rd_pend--;
         end else if ($urandom_range(3) == 0) begin
            mem_rd_valid = 1; mem_rd_last = 0;
         end
         if (wr_pend > 0 && ($urandom_range(99) < wr_cpl_prob)) begin
            mem_wr_done = 1; wr_pend--;
         end
         if (inject_req != inject_seen) begin
            mem_wr_done = 1; inject_seen = inject_req;
         end
         mem_cmd_ready = ($urandom_range(99) < rdy_prob);
      end
   end

   // Reference model: tracks outstanding bursts, starvation run and the command in flight.
   initial begin
      int m_rd = 0, m_wr = 0, m_starve = 0, rd_net, wr_net;
      bit m_iss = 0, m_iss_wr = 0, m_err = 0, rd_el, wr_el, g_rd, g_wr;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_rd = 0; m_wr = 0; m_starve = 0; m_iss = 0; m_iss_wr = 0; m_err = 0;
            exp_q.delete();
            continue;
         end
         rd_el = rd_req_valid && (m_rd < MAX_RD);
         wr_el = wr_req_valid && (m_wr < MAX_WR);
         g_wr  = !m_iss && wr_el && (m_starve == LIMIT || !rd_el);
         g_rd  = !m_iss && rd_el && !g_wr;
         check("rd_req_ready", rd_req_ready, g_rd);
         check("wr_req_ready", wr_req_ready, g_wr);
         check("mem_cmd_valid", mem_cmd_valid, m_iss);
         check("rd_busy", rd_busy, (m_rd != 0) || (m_iss && !m_iss_wr));
         check("wr_busy", wr_busy, (m_wr != 0) || (m_iss && m_iss_wr));
         check("err_underflow", err_underflow, m_err);

         rd_net = int'(m_iss && mem_cmd_ready && !m_iss_wr) - int'(mem_rd_valid && mem_rd_last);
         wr_net = int'(m_iss && mem_cmd_ready && m_iss_wr) - int'(mem_wr_done);
         if (m_rd + rd_net < 0) m_err = 1; else m_rd += rd_net;
         if (m_wr + wr_net < 0) m_err = 1; else m_wr += wr_net;

         if (!wr_req_valid || g_wr) m_starve = 0;
         else if (g_rd && m_starve < LIMIT) m_starve++;

         if (m_iss && mem_cmd_ready) begin
            m_iss = 0;
         end else if (g_rd || g_wr) begin
            m_iss    = 1;
            m_iss_wr = g_wr;
            exp_q.push_back(g_wr ? cmd_t'{1'b1, wr_req_addr, wr_req_len}
                                 : cmd_t'{1'b0, rd_req_addr, rd_req_len});
         end
      end
   end

   // Monitor: every accepted command must match the oldest predicted grant.
   initial begin
      cmd_t e, prev;
      bit   prev_stall = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0;
            continue;
         end
         if (prev_stall) begin
            check("cmd_hold_valid", mem_cmd_valid, 1);
            check("cmd_hold_write", mem_cmd_write, prev.write);
            check("cmd_hold_addr", mem_cmd_addr, prev.addr);
            check("cmd_hold_len", mem_cmd_len, prev.len);
         end
         if (mem_cmd_valid && mem_cmd_ready) begin
            if (exp_q.size() == 0) begin
               check("cmd_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("cmd_write", mem_cmd_write, e.write);
               check("cmd_addr", mem_cmd_addr, e.addr);
               check("cmd_len", mem_cmd_len, e.len);
            end
         end
         prev_stall = mem_cmd_valid && !mem_cmd_ready;
         prev       = '{mem_cmd_write, mem_cmd_addr, mem_cmd_len};
      end
   end

   task automatic wait_for(input string name, input int sel, input int budget);
      bit seen = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if ((sel == 0 && rd_req_ready) || (sel == 1 && wr_req_ready) || (sel == 2 && mem_cmd_valid)) begin
            seen = 1;
            break;
         end
      end
      check(name, seen, 1);
   endtask

   initial begin
      string got;
      int    rd_grants;

      // Reset values, with both requesters already asserting valid.
      rd_prob = 100; wr_prob = 100; rdy_prob = 100;
      repeat (3) @(negedge clk);
      #1;
      check("rst_rd_req_valid_seen", rd_req_valid, 1);
      check("rst_rd_req_ready", rd_req_ready, 0);
      check("rst_wr_req_ready", wr_req_ready, 0);
      check("rst_mem_cmd_valid", mem_cmd_valid, 0);
      check("rst_mem_cmd_write", mem_cmd_write, 0);
      check("rst_mem_cmd_addr", mem_cmd_addr, 0);
      check("rst_mem_cmd_len", mem_cmd_len, 0);
      check("rst_rd_busy", rd_busy, 0);
      check("rst_wr_busy", wr_busy, 0);
      check("rst_err_underflow", err_underflow, 0);
      @(posedge clk);
      #2 rst_n = 1;

      // Continuous read and write demand: four reads, then the starving write.
      got = "";
      for (int c = 0; c < 200 && got.len() < 10; c++) begin
         @(negedge clk);
         #1;
         if (rd_req_ready) got = {got, "R"};
         if (wr_req_ready) got = {got, "W"};
      end
      checks++;
      if (got != "RRRRWRRRRW") begin
         failures++;
         $display("FAIL grant_order: got %s expected RRRRWRRRRW", got);
      end

      // Randomized traffic with drops, back-pressure and delayed completions.
      rd_prob = 50; wr_prob = 50; rdy_prob = 60; rd_cpl_prob = 30; wr_cpl_prob = 30; drop_prob = 5;
      repeat (1500) @(negedge clk);
      rd_prob = 0; wr_prob = 0; rdy_prob = 100; rd_cpl_prob = 100; wr_cpl_prob = 100; drop_prob = 0;
      repeat (60) @(negedge clk);

      // Read credit cap: no read completions, so exactly MAX_RD reads issue.
      rd_cpl_prob = 0; rd_prob = 100;
      rd_grants = 0;
      repeat (40) begin
         @(negedge clk);
         if (rd_req_ready) rd_grants++;
      end
      check("rd_cap_grants", rd_grants, MAX_RD);
      check("rd_cap_busy", rd_busy, 1);
      wr_prob = 100;
      wait_for("wr_granted_while_rd_capped", 1, 20);
      wr_prob = 0;
      rd_cpl_prob = 100;
      wait_for("rd_granted_after_last", 0, 30);
      rd_prob = 0;
      repeat (40) @(negedge clk);

      // Long back-pressure: the monitor checks the held command every cycle.
      rdy_prob = 0; rd_prob = 100;
      wait_for("stall_cmd_valid", 2, 30);
      repeat (10) @(negedge clk);
      check("stall_still_valid", mem_cmd_valid, 1);
      rd_prob = 0; rdy_prob = 100;
      repeat (40) @(negedge clk);

      // Reset while a command waits for acceptance.
      rdy_prob = 0; rd_prob = 100;
      wait_for("issue_before_reset", 2, 30);
      #2 rst_n = 0;
      #1;
      check("async_rst_cmd_valid", mem_cmd_valid, 0);
      check("async_rst_rd_req_ready", rd_req_ready, 0);
      check("async_rst_wr_req_ready", wr_req_ready, 0);
      rd_prob = 0; rdy_prob = 100;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      #1;
      check("post_rst_rd_busy", rd_busy, 0);
      check("post_rst_wr_busy", wr_busy, 0);
      check("post_rst_err", err_underflow, 0);

      // Write completion with nothing outstanding.
      inject_req++;
      repeat (3) @(negedge clk);
      #1;
      check("underflow_err", err_underflow, 1);
      check("underflow_wr_busy", wr_busy, 0);

      rd_prob = 100;
      wait_for("grant_after_reset", 0, 30);
      rd_prob = 0;
      repeat (40) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
